// File: rtl/rsa_two_power_mod.sv
// -----------------------------------------------------------------------------
// rsa_two_power_mod
//
// Computes 2^e mod N by repeated modular doubling, one doubling per clock.
// The usual use is e = 2*MOD_WIDTH, which gives the Montgomery conversion
// constant R^2 mod N that feeds the Montgomery multiplier operand port.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : asynchronous, active-low reset
//   i_valid    : request valid (sampled only while idle)
//   i_ready    : block is idle and can accept a request
//   i_power    : exponent e
//   i_modulus  : modulus N (odd, N >= 1)
//   o_valid    : result valid
//   o_ready    : consumer accepts the result (sampled only while done)
//   o_out      : result 2^e mod N
// -----------------------------------------------------------------------------
module rsa_two_power_mod #(
  parameter int MOD_WIDTH   = 256,
  parameter int POWER_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic [POWER_WIDTH-1:0] i_power,
  input  logic [MOD_WIDTH-1:0]   i_modulus,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [MOD_WIDTH-1:0]   o_out
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CALCULATE = 2'd1,
    DONE      = 2'd2
  } state_t;

  state_t                 state;
  logic [POWER_WIDTH-1:0] power_q;
  logic [POWER_WIDTH-1:0] counter;
  logic [MOD_WIDTH-1:0]   modulus_q;

  // The result register carries one extra bit so that the doubled value
  // can never overflow before the conditional subtraction.
  logic [MOD_WIDTH:0]     result;
  logic [MOD_WIDTH:0]     shifted;
  logic [MOD_WIDTH:0]     reduced;

  // One modular doubling step: since r < N, 2r < 2N, so a single
  // conditional subtraction brings the value back below N.
  always_comb begin
    shifted = result << 1;
    reduced = shifted;
    if (shifted >= {1'b0, modulus_q}) begin
      reduced = shifted - {1'b0, modulus_q};
    end
  end

  // Control FSM and datapath registers. The counter runs from 0 up to e;
  // the edge on which it already equals e moves to DONE without touching r.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      counter   <= '0;
      result    <= '0;
      power_q   <= '0;
      modulus_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            power_q   <= i_power;
            modulus_q <= i_modulus;
            counter   <= '0;
            // 2^0 mod 1 is 0, every other modulus starts from 1
            result    <= (i_modulus == MOD_WIDTH'(1)) ? '0 : (MOD_WIDTH+1)'(1);
            state     <= CALCULATE;
          end
        end
        CALCULATE: begin
          if (counter < power_q) begin
            result  <= reduced;
            counter <= counter + POWER_WIDTH'(1);
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          if (o_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign i_ready = (state == IDLE);
  assign o_valid = (state == DONE);
  assign o_out   = result[MOD_WIDTH-1:0];

endmodule

// File: tb/tb_rsa_two_power_mod.sv
// -----------------------------------------------------------------------------
// tb_rsa_two_power_mod
//
// Self-checking bench for rsa_two_power_mod at the default 256-bit width.
// A table of {e, N, expected} records is run through a full request /
// response handshake each, followed by hand-written sequences for
// backpressure, reset in the middle of an operation and back-to-back
// requests. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_rsa_two_power_mod;

  localparam int MW = 256;
  localparam int PW = 10;

  typedef struct {
    logic [PW-1:0] power;
    logic [MW-1:0] modulus;
    logic [MW-1:0] expected;
  } vec_t;

  logic          clk       = 1'b0;
  logic          rst       = 1'b0;
  logic          i_valid   = 1'b0;
  logic          i_ready;
  logic [PW-1:0] i_power   = '0;
  logic [MW-1:0] i_modulus = '0;
  logic          o_valid;
  logic          o_ready   = 1'b0;
  logic [MW-1:0] o_out;

  int checks_total  = 0;
  int checks_passed = 0;
  int done_count    = 0;
  logic prev_valid  = 1'b0;

  vec_t vecs[14];
  logic [MW-1:0] big_n;

  always #5 clk = ~clk;

  rsa_two_power_mod #(
    .MOD_WIDTH   (MW),
    .POWER_WIDTH (PW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .i_power   (i_power),
    .i_modulus (i_modulus),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_out     (o_out)
  );

  // Counts entries into DONE so lost or duplicated results show up.
  always @(posedge clk) begin
    #1;
    if (o_valid && !prev_valid) done_count++;
    prev_valid = o_valid;
  end

  task automatic check_output(input string name, input logic [MW-1:0] actual,
                              input logic [MW-1:0] expected);
    checks_total++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end else begin
      checks_passed++;
    end
  endtask

  // Waits for the block to be idle, presents one request and returns on the
  // falling edge right after the accept edge, with the inputs scrambled.
  task automatic apply_stimulus(input logic [PW-1:0] p, input logic [MW-1:0] n);
    int waited = 0;
    @(negedge clk);
    while (!i_ready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check_output("i_ready_before_accept", MW'(i_ready), MW'(1));
    i_valid   = 1'b1;
    i_power   = p;
    i_modulus = n;
    @(negedge clk);
    i_valid   = 1'b0;
    i_power   = ~p;
    i_modulus = ~n;
    check_output("i_ready_in_calc", MW'(i_ready), MW'(0));
  endtask

  // Counts edges from the accept edge until o_valid shows up (bounded).
  task automatic wait_for_done(input logic [PW-1:0] p, output int edges);
    edges = 0;
    while (!o_valid && edges < int'(p) + 20) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic run_vector(input string tag, input logic [PW-1:0] p,
                            input logic [MW-1:0] n, input logic [MW-1:0] expected);
    int edges;
    apply_stimulus(p, n);
    wait_for_done(p, edges);
    check_output({tag, "_latency"}, MW'(edges), MW'(int'(p) + 1));
    check_output({tag, "_o_out"}, o_out, expected);
    o_ready = 1'b1;
    @(negedge clk);
    check_output({tag, "_o_valid_dropped"}, MW'(o_valid), MW'(0));
    check_output({tag, "_i_ready_back"}, MW'(i_ready), MW'(1));
    o_ready = 1'b0;
  endtask

  initial begin
    int edges;
    int done_before;

    big_n = ~MW'(188);  // 2^256 - 189

    vecs[0]  = '{power: 10'd4,   modulus: MW'(13),   expected: MW'(3)};
    vecs[1]  = '{power: 10'd0,   modulus: MW'(13),   expected: MW'(1)};
    vecs[2]  = '{power: 10'd7,   modulus: MW'(1),    expected: MW'(0)};
    vecs[3]  = '{power: 10'd10,  modulus: MW'(11),   expected: MW'(1)};
    vecs[4]  = '{power: 10'd12,  modulus: MW'(13),   expected: MW'(1)};
    vecs[5]  = '{power: 10'd3,   modulus: MW'(7),    expected: MW'(1)};
    vecs[6]  = '{power: 10'd8,   modulus: MW'(255),  expected: MW'(1)};
    vecs[7]  = '{power: 10'd5,   modulus: MW'(17),   expected: MW'(15)};
    vecs[8]  = '{power: 10'd1,   modulus: MW'(3),    expected: MW'(2)};
    vecs[9]  = '{power: 10'd0,   modulus: MW'(1),    expected: MW'(0)};
    vecs[10] = '{power: 10'd9,   modulus: MW'(1021), expected: MW'(512)};
    vecs[11] = '{power: 10'd512, modulus: big_n,     expected: MW'(35721)};
    vecs[12] = '{power: 10'd256, modulus: big_n,     expected: MW'(189)};
    vecs[13] = '{power: 10'd257, modulus: big_n,     expected: MW'(378)};

    // Reset state
    @(negedge clk);
    check_output("reset_i_ready", MW'(i_ready), MW'(1));
    check_output("reset_o_valid", MW'(o_valid), MW'(0));
    check_output("reset_o_out", o_out, MW'(0));
    @(negedge clk);
    rst = 1'b1;

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      run_vector($sformatf("vec%0d", i), vecs[i].power, vecs[i].modulus,
                 vecs[i].expected);
    end

    // Backpressure: hold the result while the inputs wiggle
    $display("[TB] backpressure sequence");
    apply_stimulus(10'd4, MW'(13));
    wait_for_done(10'd4, edges);
    check_output("bp_latency", MW'(edges), MW'(5));
    for (int k = 0; k < 5; k++) begin
      o_ready   = 1'b0;
      i_valid   = k[0];
      i_modulus = MW'($urandom);
      i_power   = PW'($urandom);
      @(negedge clk);
      check_output("bp_o_valid", MW'(o_valid), MW'(1));
      check_output("bp_o_out", o_out, MW'(3));
      check_output("bp_i_ready", MW'(i_ready), MW'(0));
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    @(negedge clk);
    check_output("bp_release_o_valid", MW'(o_valid), MW'(0));
    check_output("bp_release_i_ready", MW'(i_ready), MW'(1));
    o_ready = 1'b0;

    // Reset in the middle of a long operation
    $display("[TB] reset mid-operation sequence");
    apply_stimulus(10'd512, big_n);
    repeat (100) @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("midrst_i_ready", MW'(i_ready), MW'(1));
    check_output("midrst_o_valid", MW'(o_valid), MW'(0));
    check_output("midrst_o_out", o_out, MW'(0));
    @(negedge clk);
    check_output("midrst_hold_o_valid", MW'(o_valid), MW'(0));
    rst = 1'b1;
    run_vector("after_rst", 10'd4, MW'(13), MW'(3));

    // Back-to-back requests with i_valid held high
    $display("[TB] back-to-back sequence");
    done_before = done_count;
    @(negedge clk);
    i_valid   = 1'b1;
    i_power   = 10'd4;
    i_modulus = MW'(13);
    @(negedge clk);
    check_output("b2b_first_accepted", MW'(i_ready), MW'(0));
    wait_for_done(10'd4, edges);
    check_output("b2b_first_latency", MW'(edges), MW'(5));
    check_output("b2b_first_o_out", o_out, MW'(3));
    i_power   = 10'd10;
    i_modulus = MW'(11);
    o_ready   = 1'b1;
    @(negedge clk);
    check_output("b2b_idle_i_ready", MW'(i_ready), MW'(1));
    check_output("b2b_idle_o_valid", MW'(o_valid), MW'(0));
    o_ready = 1'b0;
    @(negedge clk);
    check_output("b2b_second_accepted", MW'(i_ready), MW'(0));
    i_valid = 1'b0;
    wait_for_done(10'd10, edges);
    check_output("b2b_second_latency", MW'(edges), MW'(11));
    check_output("b2b_second_o_out", o_out, MW'(1));
    o_ready = 1'b1;
    @(negedge clk);
    o_ready = 1'b0;
    check_output("b2b_done_count", MW'(done_count - done_before), MW'(2));

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
